cache_control: RTL and testbench

- Sequencing FSM for the 2-way, 8-set, 16-byte-line write-back cache datapath (`cache_datapath`).
- Accepts CPU read/write requests and drives hit responses, word writes, the LRU update, victim write-back and line allocation over the physical-memory handshake.
- Sits between the CPU memory port, `cache_datapath` and physical memory.

---
 rtl/cache_control_pkg.sv | 17 +
 rtl/cache_control_if.sv | 60 ++++++
 rtl/cache_wmask_gen.sv | 16 +
 rtl/cache_control.sv | 110 +++++++++++
 tb/tb_cache_control.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_control_pkg.sv
// Shared types and constants for the 2-way, 8-set, 16-byte-line write-back cache controller.
package cache_control_pkg;

  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC
  } cache_state_t;

  localparam logic [1:0] ADR_REQ  = 2'd0;
  localparam logic [1:0] ADR_TAG0 = 2'd1;
  localparam logic [1:0] ADR_TAG1 = 2'd2;

endpackage

// File: rtl/cache_control_if.sv
// CPU port, datapath status/strobes and pmem handshake seen by the cache controller.
interface cache_control_if;
  import cache_control_pkg::*;

  // CPU side
  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  logic [2:0]    word_offset;
  logic          mem_resp;

  // Physical memory side
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;

  // Datapath status
  logic          hit0;
  logic          hit1;
  logic          valid0_out;
  logic          valid1_out;
  logic          dirty0_out;
  logic          dirty1_out;
  logic          LRU_out;

  // Datapath control
  logic          data0_writeline;
  logic          data1_writeline;
  logic          tag0_write;
  logic          tag1_write;
  logic          valid0_write;
  logic          valid1_write;
  logic          dirty0_write;
  logic          dirty1_write;
  logic          valid_in;
  logic          dirty_in;
  logic          updateLRU;
  logic          wb_sel;
  lc3b_word      offset_sel;
  logic [1:0]    adrmux_sel;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, word_offset, pmem_resp,
           hit0, hit1, valid0_out, valid1_out, dirty0_out, dirty1_out, LRU_out,
    output mem_resp, pmem_read, pmem_write,
           data0_writeline, data1_writeline, tag0_write, tag1_write,
           valid0_write, valid1_write, dirty0_write, dirty1_write,
           valid_in, dirty_in, updateLRU, wb_sel, offset_sel, adrmux_sel
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, word_offset, pmem_resp,
           hit0, hit1, valid0_out, valid1_out, dirty0_out, dirty1_out, LRU_out,
    input  mem_resp, pmem_read, pmem_write,
           data0_writeline, data1_writeline, tag0_write, tag1_write,
           valid0_write, valid1_write, dirty0_write, dirty1_write,
           valid_in, dirty_in, updateLRU, wb_sel, offset_sel, adrmux_sel
  );

endinterface

// File: rtl/cache_wmask_gen.sv
// Expands a word offset and its two byte enables into a 16-bit byte mask over the line.
module cache_wmask_gen
  import cache_control_pkg::*;
(
  input  logic [2:0]    word_offset_i,
  input  lc3b_mem_wmask byte_enable_i,
  output lc3b_word      offset_sel_o
);

  always_comb begin
    offset_sel_o = '0;
    offset_sel_o[{word_offset_i, 1'b0}] = byte_enable_i[0];
    offset_sel_o[{word_offset_i, 1'b1}] = byte_enable_i[1];
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back cache: hit compare, victim write-back, line fill.
module cache_control
  import cache_control_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cache_control_if.slave bus
);

  cache_state_t state_q, state_d;
  logic         victim_q, victim_d;

  logic       request, hit, hit_way;
  lc3b_word   wmask;
  logic [1:0] data_wl, tag_w, valid_w, dirty_w;

  cache_wmask_gen u_wmask_gen (
    .word_offset_i (bus.word_offset),
    .byte_enable_i (bus.mem_byte_enable),
    .offset_sel_o  (wmask)
  );

  assign request = (bus.mem_read | bus.mem_write) & ~reset;
  assign hit     = bus.hit0 | bus.hit1;
  assign hit_way = ~bus.hit0;  // way0 wins when both hit

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    data_wl        = '0;
    tag_w          = '0;
    valid_w        = '0;
    dirty_w        = '0;
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.valid_in   = 1'b0;
    bus.dirty_in   = 1'b0;
    bus.updateLRU  = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.offset_sel = '0;
    bus.adrmux_sel = ADR_REQ;

    unique case (state_q)
      S_IDLE: begin
        if (request && hit) begin
          bus.mem_resp  = 1'b1;
          // LRU_out=1 names way0 as the candidate; touching the candidate flips it.
          bus.updateLRU = hit_way ? ~bus.LRU_out : bus.LRU_out;
          if (bus.mem_write) begin
            data_wl[hit_way] = 1'b1;
            dirty_w[hit_way] = 1'b1;
            bus.dirty_in     = 1'b1;
            bus.wb_sel       = 1'b1;
            bus.offset_sel   = wmask;
          end
        end else if (request) begin
          if (!bus.valid0_out) begin
            victim_d = 1'b0;
            state_d  = S_ALLOC;
          end else if (!bus.valid1_out) begin
            victim_d = 1'b1;
            state_d  = S_ALLOC;
          end else begin
            victim_d = ~bus.LRU_out;
            state_d  = (bus.LRU_out ? bus.dirty0_out : bus.dirty1_out) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        bus.pmem_write = 1'b1;
        bus.adrmux_sel = victim_q ? ADR_TAG1 : ADR_TAG0;
        if (bus.pmem_resp) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          // Arrays are written only here, so an interrupted fill leaves no trace.
          data_wl[victim_q] = 1'b1;
          tag_w[victim_q]   = 1'b1;
          valid_w[victim_q] = 1'b1;
          dirty_w[victim_q] = 1'b1;
          bus.valid_in      = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data0_writeline = data_wl[0];
  assign bus.data1_writeline = data_wl[1];
  assign bus.tag0_write      = tag_w[0];
  assign bus.tag1_write      = tag_w[1];
  assign bus.valid0_write    = valid_w[0];
  assign bus.valid1_write    = valid_w[1];
  assign bus.dirty0_write    = dirty_w[0];
  assign bus.dirty1_write    = dirty_w[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: table of compare-state vectors plus miss/reset sequences.
module tb_cache_control;
  import cache_control_pkg::*;

  logic clk;
  logic reset;
  cache_control_if bus ();

  cache_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  data_wl;
    logic [1:0]  tag_w;
    logic [1:0]  valid_w;
    logic [1:0]  dirty_w;
    logic        valid_in;
    logic        dirty_in;
    logic        update_lru;
    logic        wb_sel;
    logic [15:0] offset_sel;
    logic [1:0]  adrmux_sel;
  } outs_t;

  typedef struct {
    string      name;
    logic       rd, wr;
    logic [1:0] be;
    logic [2:0] wo;
    logic       h0, h1, lru;
    outs_t      exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  outs_t exp_q[$];
  string name_q[$];
  vec_t tbl[11];

  function automatic outs_t o_none();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t o_hit(logic upd, logic wr, int way, logic [15:0] off);
    outs_t o = '0;
    o.mem_resp   = 1'b1;
    o.update_lru = upd;
    if (wr) begin
      o.data_wl[way] = 1'b1;
      o.dirty_w[way] = 1'b1;
      o.dirty_in     = 1'b1;
      o.wb_sel       = 1'b1;
      o.offset_sel   = off;
    end
    return o;
  endfunction

  function automatic outs_t o_wb(int way);
    outs_t o = '0;
    o.pmem_write = 1'b1;
    o.adrmux_sel = (way == 1) ? 2'd2 : 2'd1;
    return o;
  endfunction

  function automatic outs_t o_alloc(logic resp, int way);
    outs_t o = '0;
    o.pmem_read = 1'b1;
    if (resp) begin
      o.data_wl[way] = 1'b1;
      o.tag_w[way]   = 1'b1;
      o.valid_w[way] = 1'b1;
      o.dirty_w[way] = 1'b1;
      o.valid_in     = 1'b1;
    end
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.mem_resp   = bus.mem_resp;
    o.pmem_read  = bus.pmem_read;
    o.pmem_write = bus.pmem_write;
    o.data_wl    = {bus.data1_writeline, bus.data0_writeline};
    o.tag_w      = {bus.tag1_write, bus.tag0_write};
    o.valid_w    = {bus.valid1_write, bus.valid0_write};
    o.dirty_w    = {bus.dirty1_write, bus.dirty0_write};
    o.valid_in   = bus.valid_in;
    o.dirty_in   = bus.dirty_in;
    o.update_lru = bus.updateLRU;
    o.wb_sel     = bus.wb_sel;
    o.offset_sel = bus.offset_sel;
    o.adrmux_sel = bus.adrmux_sel;
    return o;
  endfunction

  function automatic vec_t mkv(string n, logic rd, logic wr, logic [1:0] be, logic [2:0] wo,
                               logic h0, logic h1, logic lru, outs_t e);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.be = be; v.wo = wo;
    v.h0 = h0; v.h1 = h1; v.lru = lru; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string nm, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [1:0] be,
                           input logic [2:0] wo);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_byte_enable = be; bus.word_offset = wo;
  endtask

  task automatic drive_dp(input logic h0, input logic h1, input logic v0, input logic v1,
                          input logic d0, input logic d1, input logic lru);
    bus.hit0 = h0; bus.hit1 = h1; bus.valid0_out = v0; bus.valid1_out = v1;
    bus.dirty0_out = d0; bus.dirty1_out = d1; bus.LRU_out = lru;
  endtask

  // Expectation queued with the stimulus, retired when the cycle's outputs are sampled.
  task automatic cyc(input string nm, input outs_t e);
    outs_t exp;
    string n;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    exp = exp_q.pop_front();
    n   = name_q.pop_front();
    compare(n, sample(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mkv("no_req",          0, 0, 2'b11, 3'd2, 1, 0, 1, o_none());
    tbl[1]  = mkv("rd_hit0_lru1",    1, 0, 2'b00, 3'd0, 1, 0, 1, o_hit(1, 0, 0, 16'h0));
    tbl[2]  = mkv("rd_hit0_lru0",    1, 0, 2'b00, 3'd0, 1, 0, 0, o_hit(0, 0, 0, 16'h0));
    tbl[3]  = mkv("rd_hit1_lru1",    1, 0, 2'b00, 3'd1, 0, 1, 1, o_hit(0, 0, 1, 16'h0));
    tbl[4]  = mkv("rd_hit1_lru0",    1, 0, 2'b00, 3'd1, 0, 1, 0, o_hit(1, 0, 1, 16'h0));
    tbl[5]  = mkv("wr_hit0_w2_b01",  0, 1, 2'b01, 3'd2, 1, 0, 0, o_hit(0, 1, 0, 16'h0010));
    tbl[6]  = mkv("wr_hit1_w7_b11",  0, 1, 2'b11, 3'd7, 0, 1, 0, o_hit(1, 1, 1, 16'hC000));
    tbl[7]  = mkv("wr_bothhit_w0",   0, 1, 2'b10, 3'd0, 1, 1, 1, o_hit(1, 1, 0, 16'h0002));
    tbl[8]  = mkv("rdwr_hit1_w3",    1, 1, 2'b11, 3'd3, 0, 1, 1, o_hit(0, 1, 1, 16'h00C0));
    tbl[9]  = mkv("wr_hit0_be00",    0, 1, 2'b00, 3'd5, 1, 0, 0, o_hit(0, 1, 0, 16'h0000));
    tbl[10] = mkv("rd_hit_no_mask",  1, 0, 2'b11, 3'd4, 1, 0, 1, o_hit(1, 0, 0, 16'h0));

    reset = 1'b1;
    bus.pmem_resp = 1'b0;
    drive_req(0, 0, 2'b00, 3'd0);
    drive_dp(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    compare("reset_outputs", sample(), o_none());
    reset = 1'b0;
    cyc("idle_after_reset", o_none());

    for (int i = 0; i < 11; i++) begin
      drive_req(tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].wo);
      drive_dp(tbl[i].h0, tbl[i].h1, 1, 1, 0, 0, tbl[i].lru);
      cyc(tbl[i].name, tbl[i].exp);
    end

    // Cold read of 0x0120 into empty set
    drive_dp(0, 0, 0, 0, 0, 0, 1);
    drive_req(1, 0, 2'b00, 3'd0);
    cyc("A_miss", o_none());
    cyc("A_alloc_wait", o_alloc(0, 0));
    bus.pmem_resp = 1'b1;
    cyc("A_fill_way0", o_alloc(1, 0));
    bus.pmem_resp = 1'b0;
    drive_dp(1, 0, 1, 0, 0, 0, 1);
    cyc("A_hit_after_fill", o_hit(1, 0, 0, 16'h0));

    // Dirty LRU victim way0: write-back then fill
    drive_dp(0, 0, 1, 1, 1, 0, 1);
    drive_req(0, 1, 2'b01, 3'd2);
    cyc("B_miss", o_none());
    cyc("B_wb_0", o_wb(0));
    cyc("B_wb_1", o_wb(0));
    bus.pmem_resp = 1'b1;
    cyc("B_wb_resp", o_wb(0));
    bus.pmem_resp = 1'b0;
    cyc("B_alloc_wait", o_alloc(0, 0));
    bus.pmem_resp = 1'b1;
    cyc("B_fill_way0", o_alloc(1, 0));
    bus.pmem_resp = 1'b0;
    drive_dp(1, 0, 1, 1, 0, 0, 1);
    cyc("B_write_merge", o_hit(1, 1, 0, 16'h0010));

    // Clean LRU victim way1: no write-back
    drive_dp(0, 0, 1, 1, 0, 0, 0);
    drive_req(1, 0, 2'b00, 3'd1);
    cyc("C_miss", o_none());
    bus.pmem_resp = 1'b1;
    cyc("C_fill_way1", o_alloc(1, 1));
    bus.pmem_resp = 1'b0;
    drive_dp(0, 1, 1, 1, 0, 0, 0);
    cyc("C_hit_after_fill", o_hit(1, 0, 1, 16'h0));

    // Invalid way1 wins over dirty LRU way0; request dropped mid-fill
    drive_dp(0, 0, 1, 0, 1, 0, 1);
    drive_req(1, 0, 2'b00, 3'd3);
    cyc("D_miss", o_none());
    drive_req(0, 0, 2'b00, 3'd3);
    cyc("D_alloc_noreq", o_alloc(0, 1));
    bus.pmem_resp = 1'b1;
    cyc("D_fill_way1", o_alloc(1, 1));
    bus.pmem_resp = 1'b0;
    cyc("D_no_mem_resp", o_none());

    // Reset during S_ALLOC before pmem_resp
    drive_dp(0, 0, 0, 0, 0, 0, 1);
    drive_req(1, 0, 2'b00, 3'd0);
    cyc("E_miss", o_none());
    cyc("E_alloc_wait", o_alloc(0, 0));
    bus.pmem_resp = 1'b1;
    reset = 1'b1;
    #1;
    compare("E_reset_async", sample(), o_none());
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("E_idle_after_release", o_none());
    cyc("E_refill_way0", o_alloc(1, 0));
    bus.pmem_resp = 1'b0;
    drive_req(0, 0, 2'b00, 3'd0);
    cyc("E_idle_end", o_none());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
